camera_sensor_emulator: RTL

Synthetic camera sensor source producing the frame_valid / line_valid / pixel-data stream that the capture path consumes. It sits in place of the physical sensor for bring-up, simulation and board self-test, so the capture, position and VGA paths can run without optics. It generates configurable frame geometry and blanking, several deterministic test patterns, and single-shot or continuous frames.

---
 rtl/camera_sensor_emulator.sv | 116 +++++++++++
 1 files changed

// File: rtl/camera_sensor_emulator.sv
// camera_sensor_emulator: synthetic FVAL/LVAL/pixel source with programmable geometry, blanking and test patterns
module camera_sensor_emulator #(
   parameter int N       = 12,
   parameter int FV_HEAD = 2,
   parameter int H_BLANK = 3,
   parameter int FV_TAIL = 2,
   parameter int V_BLANK = 5
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic [11:0]   in_columns,
   input  logic [11:0]   in_rows,
   input  logic [1:0]    in_pattern,
   input  logic          in_start,
   input  logic          in_continuous,
   input  logic          in_stop,
   output logic          out_frame_valid,
   output logic          out_line_valid,
   output logic [N-1:0]  out_data,
   output logic          out_busy,
   output logic [31:0]   out_frame_count
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] HEAD   = 3'd1;
   localparam logic [2:0] LINE   = 3'd2;
   localparam logic [2:0] HBLANK = 3'd3;
   localparam logic [2:0] TAIL   = 3'd4;
   localparam logic [2:0] VBLANK = 3'd5;
   localparam logic [15:0] HEAD_END = 16'(FV_HEAD - 1);
   localparam logic [15:0] HB_END   = 16'(H_BLANK - 1);
   localparam logic [15:0] TAIL_END = 16'(FV_TAIL - 1);
   localparam logic [15:0] VB_END   = 16'(V_BLANK - 1);

   logic [2:0]   state;
   logic [15:0]  cnt;
   logic [11:0]  cols, rows, x, y;
   logic [1:0]   pat;
   logic [N-1:0] pix, pix_value;
   logic         stop_pending, geom_ok;

   assign geom_ok   = in_columns != 12'd0 && in_rows != 12'd0;
   assign pix_value = pat == 2'd0 ? pix :
                      pat == 2'd1 ? N'(x) :
                      pat == 2'd2 ? N'(y) : {N{x[3] ^ y[3]}};

   // Outputs are registered views of the state, so they trail the FSM by one cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         cnt             <= '0;
         cols            <= '0;
         rows            <= '0;
         x               <= '0;
         y               <= '0;
         pat             <= '0;
         pix             <= '0;
         stop_pending    <= 1'b0;
         out_frame_valid <= 1'b0;
         out_line_valid  <= 1'b0;
         out_data        <= '0;
         out_busy        <= 1'b0;
         out_frame_count <= '0;
      end else begin
         out_frame_valid <= state inside {HEAD, LINE, HBLANK, TAIL};
         out_line_valid  <= state == LINE;
         out_data        <= state == LINE ? pix_value : '0;
         out_busy        <= state != IDLE;
         if (out_frame_valid && state == VBLANK) out_frame_count <= out_frame_count + 32'd1;
         if (state != IDLE && in_stop) stop_pending <= 1'b1;
         case (state)
            IDLE: if (in_start && geom_ok) begin
               cols  <= in_columns;
               rows  <= in_rows;
               pat   <= in_pattern;
               cnt   <= '0;
               state <= HEAD;
            end
            HEAD: if (cnt == HEAD_END) begin
               x     <= '0;
               y     <= '0;
               pix   <= '0;
               state <= LINE;
            end else cnt <= cnt + 16'd1;
            LINE: begin
               x   <= x + 12'd1;
               pix <= pix + N'(1);
               if (x == cols - 12'd1) begin
                  cnt   <= '0;
                  state <= y == rows - 12'd1 ? TAIL : HBLANK;
               end
            end
            HBLANK: if (cnt == HB_END) begin
               x     <= '0;
               y     <= y + 12'd1;
               state <= LINE;
            end else cnt <= cnt + 16'd1;
            TAIL: if (cnt == TAIL_END) begin
               cnt   <= '0;
               state <= VBLANK;
            end else cnt <= cnt + 16'd1;
            VBLANK: if (cnt != VB_END) cnt <= cnt + 16'd1;
            else if (in_continuous && !stop_pending && !in_stop && geom_ok) begin
               cols  <= in_columns;
               rows  <= in_rows;
               pat   <= in_pattern;
               cnt   <= '0;
               state <= HEAD;
            end else begin
               stop_pending <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
